sdf_r2_stage: RTL and testbench

//  Parametrised radix-2 single-delay-feedback (SDF) FFT/butterfly stage.

---
 rtl/sdf_r2_stage.sv | 110 +++++++++++
 tb/tb_sdf_r2_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-delay-feedback butterfly stage with internal delay line and phase counter.
// Define SDF_SCALE_EN to halve butterfly results (round-half-up) for a fixed output width.
module sdf_r2_stage #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic                    sof,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic                    out_phase,
    output logic signed [WIDTH:0]   out_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CW    = LOG2_DEPTH + 1;
    localparam int OW    = WIDTH + 1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 primed_q, primed_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_phase_q, out_phase_d;
    logic signed [OW-1:0] out_data_q, out_data_d;
    logic signed [OW-1:0] dl_q [DEPTH];
    logic signed [OW-1:0] dl_d [DEPTH];

    logic [CW-1:0]        idx;
    logic                 phase;
    logic signed [OW-1:0] head;
    logic signed [OW-1:0] in_ext;
    logic signed [OW-1:0] sum_r;
    logic signed [OW-1:0] diff_r;

`ifdef SDF_SCALE_EN
    logic signed [OW:0]   sum_full;
    logic signed [OW:0]   diff_full;

    // (x + 1) >>> 1 == (x >>> 1) + x[0]; the result always fits in OW bits
    always_comb begin
        sum_full  = {head[OW-1], head} + {{2{in_data[WIDTH-1]}}, in_data};
        diff_full = {head[OW-1], head} - {{2{in_data[WIDTH-1]}}, in_data};
        sum_r     = sum_full[OW:1] + {{(OW-1){1'b0}}, sum_full[0]};
        diff_r    = diff_full[OW:1] + {{(OW-1){1'b0}}, diff_full[0]};
    end
`else
    always_comb begin
        sum_r  = head + in_ext;
        diff_r = head - in_ext;
    end
`endif

    always_comb begin
        idx    = sof ? '0 : cnt_q;
        phase  = idx[CW-1];
        head   = dl_q[0];
        in_ext = {in_data[WIDTH-1], in_data};
    end

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        out_phase_d = out_phase_q;
        out_data_d  = out_data_q;
        dl_d        = dl_q;
        if (in_valid) begin
            // counter wraps naturally at 2*DEPTH
            cnt_d = idx + CW'(1);
            for (int i = 0; i < DEPTH - 1; i++) begin
                dl_d[i] = dl_q[i+1];
            end
            dl_d[DEPTH-1] = phase ? diff_r : in_ext;
            if (phase) begin
                primed_d = 1'b1;
            end
            out_valid_d = primed_q | phase;
            if (out_valid_d) begin
                out_phase_d = phase;
                out_data_d  = phase ? sum_r : head;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_phase_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_phase_q <= out_phase_d;
            out_data_q  <= out_data_d;
            dl_q        <= dl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_phase = out_phase_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Randomised and directed bench for sdf_r2_stage against a push-history reference model.
// Builds with or without SDF_SCALE_EN; expectations follow the same macro.
module tb_sdf_r2_stage;

    localparam int D = 4;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic sof = 1'b0;
    logic signed [7:0] in_data = '0;
    logic out_valid;
    logic out_phase;
    logic signed [8:0] out_data;

    logic in_valid0 = 1'b0;
    logic sof0 = 1'b0;
    logic signed [7:0] in_data0 = '0;
    logic out_valid0;
    logic out_phase0;
    logic signed [8:0] out_data0;

    int n_tests = 0;
    int n_fail = 0;

    int m_cnt;
    bit m_primed;
    int m_q[$];
    int m_last;
    int m_lastph;
    int got[$];

    always #5 clk = ~clk;

    sdf_r2_stage #(.WIDTH(8), .LOG2_DEPTH(2)) dut (
        .clk(clk), .clear(clear), .in_valid(in_valid), .sof(sof),
        .in_data(in_data), .out_valid(out_valid), .out_phase(out_phase),
        .out_data(out_data)
    );

    sdf_r2_stage #(.WIDTH(8), .LOG2_DEPTH(0)) dut0 (
        .clk(clk), .clear(clear), .in_valid(in_valid0), .sof(sof0),
        .in_data(in_data0), .out_valid(out_valid0), .out_phase(out_phase0),
        .out_data(out_data0)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scale(input int x);
`ifdef SDF_SCALE_EN
        return (x + 1) >>> 1;
`else
        return x;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_primed = 0;
        m_q = {};
        for (int i = 0; i < D; i++) m_q.push_back(0);
        m_last = 0;
        m_lastph = 0;
    endtask

    task automatic do_clear();
        @(posedge clk);
        in_valid = 0;
        sof = 0;
        #2 clear = 1;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_phase", int'(out_phase), 0);
        @(negedge clk);
        #2 clear = 0;
        model_reset();
    endtask

    task automatic step(input bit v, input bit s, input int d);
        int idx;
        int hd;
        int ed;
        int ep;
        bit ev;
        ev = 0;
        ed = 0;
        ep = 0;
        @(negedge clk);
        in_valid = v;
        sof = s;
        in_data = d[7:0];
        if (v) begin
            idx = s ? 0 : m_cnt;
            m_cnt = (idx + 1) % (2 * D);
            hd = m_q.pop_front();
            if (idx < D) begin
                m_q.push_back(d);
                ev = m_primed;
                ed = hd;
                ep = 0;
            end else begin
                m_q.push_back(scale(hd - d));
                m_primed = 1;
                ev = 1;
                ed = scale(hd + d);
                ep = 1;
            end
            if (ev) begin
                m_last = ed;
                m_lastph = ep;
            end
        end
        @(posedge clk);
        #1;
        check("valid", int'(out_valid), int'(ev));
        if (ev || !v) begin
            check("data", int'(out_data), m_last);
            check("phase", int'(out_phase), m_lastph);
        end
        if (out_valid) got.push_back(int'(out_data));
    endtask

    task automatic feed_frame(input int gap_a, input int gap_b);
        for (int i = 0; i < 8; i++) begin
            step(1, i == 0, i + 1);
            if (i == 1) repeat (gap_a) step(0, 0, 0);
            if (i == 5) repeat (gap_b) step(0, 0, 0);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic check_frame(input string tag);
        int ef[8];
`ifdef SDF_SCALE_EN
        ef = '{3, 4, 5, 6, -2, -2, -2, -2};
`else
        ef = '{6, 8, 10, 12, -4, -4, -4, -4};
`endif
        check({tag, "_len"}, got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) check(tag, got[i], ef[i]);
    endtask

    initial begin
        model_reset();
        #3 clear = 1;
        #10 clear = 0;

        do_clear();
        got = {};
        feed_frame(0, 0);
        check_frame("frame");

        got = {};
        for (int i = 0; i < 4; i++) step(1, i == 0, -128);
        for (int i = 0; i < 4; i++) step(1, 0, 127);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        check("ext_len", got.size(), 12);
        if (got.size() == 12) begin
`ifdef SDF_SCALE_EN
            check("ext_sum", got[4], 0);
            check("ext_diff", got[8], -127);
`else
            check("ext_sum", got[4], -1);
            check("ext_diff", got[8], -255);
`endif
        end

        do_clear();
        got = {};
        feed_frame(3, 3);
        check_frame("gaps");

        step(1, 1, 10);
        step(1, 0, 20);
        step(1, 1, 30);
        for (int i = 0; i < 9; i++) step(1, 0, i * 7 - 20);

        step(1, 1, 5);
        for (int i = 0; i < 5; i++) step(1, 0, 9);
        do_clear();
        got = {};
        feed_frame(0, 0);
        check_frame("rst_mid");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 255)) - 128);
        end

        do_clear();
        @(negedge clk);
        in_valid0 = 1; sof0 = 1; in_data0 = 3;
        @(posedge clk); #1;
        check("d0_fill_valid", int'(out_valid0), 0);
        @(negedge clk);
        sof0 = 0; in_data0 = 5;
        @(posedge clk); #1;
        check("d0_sum_valid", int'(out_valid0), 1);
        check("d0_sum", int'(out_data0), scale(8));
        check("d0_sum_phase", int'(out_phase0), 1);
        @(negedge clk);
        in_data0 = 0;
        @(posedge clk); #1;
        check("d0_diff_valid", int'(out_valid0), 1);
        check("d0_diff", int'(out_data0), scale(-2));
        check("d0_diff_phase", int'(out_phase0), 0);
        @(negedge clk);
        in_valid0 = 0;
        @(posedge clk); #1;
        check("d0_idle", int'(out_valid0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
